mux_nxw_pipe: RTL and testbench

//  Parametrised, pipelined NUM_IN:1 word selector with valid/ready flow control.
//  Two-level registered tree: stage 1 selects within groups of GROUP inputs,

---
 rtl/mux_pipe_pkg.sv | 15 +
 rtl/mux_group_sel.sv | 22 ++
 rtl/mux_nxw_pipe.sv | 112 +++++++++++
 tb/tb_mux_nxw_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared sizing helpers for the pipelined NUM_IN:1 word selector.
package mux_pipe_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mux_group_sel.sv
// Combinational N:1 word select; an index at or beyond N yields an all-zero word.
module mux_group_sel
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N     = 2,
  parameter int SW    = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   word
);

  // AND-OR select: only the slot matching sel contributes, so unmatched indices give zero
  always_comb begin
    word = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      word = word | ((int'(sel) == i) ? data[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/mux_nxw_pipe.sv
// Two-stage registered NUM_IN:1 word selector with valid/ready flow control.
// Optional out-of-range select reporting is enabled by defining MUX_SEL_ERR_EN.
module mux_nxw_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 40,
  parameter int GROUP  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [clog2(NUM_IN)-1:0] in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int SEL_W = clog2(NUM_IN);
  localparam int GS_W  = clog2(GROUP);
  localparam int NG    = ceil_div(NUM_IN, GROUP);
  // When GROUP == NUM_IN there are no upper select bits; keep a 1-bit field that stays 0
  localparam int HI_W  = (SEL_W > GS_W) ? (SEL_W - GS_W) : 1;
  localparam int PAD_W = NG * GROUP * WIDTH;

  logic                s1_valid_r;
  logic                s2_valid_r;
  logic                s1_adv_s;
  logic                s2_adv_s;
  logic [GS_W-1:0]     lo_sel_s;
  logic [HI_W-1:0]     hi_sel_s;
  logic [HI_W-1:0]     hi_sel_r;
  logic [PAD_W-1:0]    pad_data_s;
  logic [NG*WIDTH-1:0] grp_next_s;
  logic [NG*WIDTH-1:0] grp_r;
  logic [WIDTH-1:0]    word_s;
  logic [WIDTH-1:0]    stage2_word_s;
  logic [WIDTH-1:0]    out_data_r;

  assign s2_adv_s = !s2_valid_r || out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  assign lo_sel_s   = in_sel[GS_W-1:0];
  assign hi_sel_s   = HI_W'(in_sel >> GS_W);
  assign pad_data_s = PAD_W'(in_data);

  for (genvar g = 0; g < NG; g++) begin : g_grp
    mux_group_sel #(.WIDTH(WIDTH), .N(GROUP), .SW(GS_W)) u_grp_sel (
      .data (pad_data_s[g*GROUP*WIDTH +: GROUP*WIDTH]),
      .sel  (lo_sel_s),
      .word (grp_next_s[g*WIDTH +: WIDTH])
    );
  end

  mux_group_sel #(.WIDTH(WIDTH), .N(NG), .SW(HI_W)) u_top_sel (
    .data (grp_r),
    .sel  (hi_sel_r),
    .word (word_s)
  );

`ifdef MUX_SEL_ERR_EN
  logic oor_s;
  logic oor_r;
  logic out_err_r;

  assign oor_s = (int'(in_sel) >= NUM_IN);

  // Range flag travels alongside the data through both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_r     <= 1'b0;
      out_err_r <= 1'b0;
    end else begin
      if (s1_adv_s && in_valid) oor_r <= oor_s;
      if (s2_adv_s && s1_valid_r) out_err_r <= oor_r;
    end
  end

  assign stage2_word_s = oor_r ? {WIDTH{1'b0}} : word_s;
  assign out_err       = out_err_r;
`else
  assign stage2_word_s = word_s;
  assign out_err       = 1'b0;
`endif

  // Data only loads on a real transfer so X on idle inputs never reaches state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      grp_r      <= {(NG*WIDTH){1'b0}};
      hi_sel_r   <= {HI_W{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
    end else begin
      if (s1_adv_s) s1_valid_r <= in_valid;
      if (s1_adv_s && in_valid) begin
        grp_r    <= grp_next_s;
        hi_sel_r <= hi_sel_s;
      end
      if (s2_adv_s) s2_valid_r <= s1_valid_r;
      if (s2_adv_s && s1_valid_r) out_data_r <= stage2_word_s;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_mux_nxw_pipe.sv
// Directed and randomized checks of mux_nxw_pipe against a scoreboard of expected words.
module tb_mux_nxw_pipe;

`ifdef MUX_SEL_ERR_EN
  localparam bit E_ERR = 1'b1;
`else
  localparam bit E_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [319:0] in_data;
  logic [5:0]   in_sel;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_err;
  logic         out_valid;
  logic         out_ready = 1'b0;

  logic [39:0]  b_data;
  logic [2:0]   b_sel;
  logic         b_valid = 1'b0;
  logic         b_in_ready;
  logic [7:0]   b_out_data;
  logic         b_out_err;
  logic         b_out_valid;

  mux_nxw_pipe #(.WIDTH(8), .NUM_IN(40), .GROUP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready));

  mux_nxw_pipe #(.WIDTH(8), .NUM_IN(5), .GROUP(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(1'b1));

  always #5 clk = ~clk;

  typedef struct { logic [5:0] sel; logic [7:0] d; logic e; } vec_t;
  typedef struct { logic [7:0] d; logic e; int t; } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  logic [7:0] cur_d;
  logic       cur_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mdl_d(input int s);
    return (s < 40) ? 8'(s + 16) : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record input transfers and match output transfers just before the edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'(out_data), 32'hffff_ffff);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          check("out_data", 32'(out_data), 32'(x.d));
          check("out_err", 32'(out_err), 32'(x.e));
          if (lat_chk) check("latency", 32'(cyc - x.t), 32'd2);
        end
      end
      if (in_valid && in_ready) sbq.push_back('{d: cur_d, e: cur_e, t: cyc});
    end
  end

  task automatic send(input logic [5:0] sel, input logic [7:0] d, input logic e);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_sel = sel; cur_d = d; cur_e = e;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    check("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0; in_sel = 6'bxxxxxx;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic small_one(input logic [2:0] sel, input logic [7:0] d, input logic e);
    b_valid = 1'b1; b_sel = sel;
    @(posedge clk); #1;
    b_valid = 1'b0; b_sel = 3'bxxx;
    @(posedge clk); #1;
    check("small_valid", 32'(b_out_valid), 32'd1);
    check("small_data", 32'(b_out_data), 32'(d));
    check("small_err", 32'(b_out_err), 32'(e));
  endtask

  initial begin
    for (int i = 0; i < 40; i++) in_data[i*8 +: 8] = 8'(i + 16);
    for (int i = 0; i < 5; i++) b_data[i*8 +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 40; i++) tbl.push_back('{sel: 6'(i), d: 8'(i + 16), e: 1'b0});
    tbl.push_back('{sel: 6'd45, d: 8'h00, e: E_ERR});
    tbl.push_back('{sel: 6'd39, d: 8'h37, e: 1'b0});
    tbl.push_back('{sel: 6'd40, d: 8'h00, e: E_ERR});
    tbl.push_back('{sel: 6'd63, d: 8'h00, e: E_ERR});
    tbl.push_back('{sel: 6'd32, d: 8'h30, e: 1'b0});
    in_sel = 6'bxxxxxx; b_sel = 3'bxxx;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    // Mid-stream reset with a word waiting at the output
    send(6'd5, 8'h15, 1'b0);
    send(6'd6, 8'h16, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_data", 32'(out_data), 32'h15);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_err", 32'(out_err), 32'd0);
    sbq.delete();
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1; lat_chk = 1'b1;
    send(6'd7, 8'h17, 1'b0);
    drain();

    // Back-to-back sweep plus range boundaries
    foreach (tbl[i]) send(tbl[i].sel, tbl[i].d, tbl[i].e);
    drain();
    lat_chk = 1'b0;

    // Backpressure on a full pipe, then simultaneous in/out transfer
    out_ready = 1'b0;
    send(6'd1, 8'h11, 1'b0);
    send(6'd2, 8'h12, 1'b0);
    in_valid = 1'b1; in_sel = 6'd3; cur_d = 8'h13; cur_e = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_hold", 32'(out_data), 32'h11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sel = 6'bxxxxxx;
    drain();

    // Randomized valid/ready traffic
    for (int k = 0; k < 2000; k++) begin
      int s;
      s = int'($urandom_range(0, 47));
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_sel = in_valid ? 6'(s) : 6'bxxxxxx;
      cur_d = mdl_d(s);
      cur_e = E_ERR && (s >= 40);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sel = 6'bxxxxxx;
    drain();
    @(negedge clk);
    check("final_idle", 32'(out_valid), 32'd0);

    // Ragged configuration: 5 inputs in groups of 4
    small_one(3'd4, 8'hA4, 1'b0);
    small_one(3'd6, 8'h00, E_ERR);
    small_one(3'd0, 8'hA0, 1'b0);
    small_one(3'd3, 8'hA3, 1'b0);
    small_one(3'd5, 8'h00, E_ERR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
